rs_encoder: RTL and testbench

RS_ENCODER -- requirements
Module: rs_encoder

---
 rtl/rs_encoder.sv | 131 +++++++++++++
 tb/tb_rs_encoder.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_encoder.sv
// Systematic Reed-Solomon encoder: message beats stream straight through, then the
// LFSR remainder is appended as parity beats, highest-degree parity symbol first.

package gf_pkg;
    localparam int SYMB_WIDTH        = 8;
    localparam int BUS_WIDTH_IN_SYMB = 4;
    localparam int ROOTS_NUM         = 6;
    localparam logic [SYMB_WIDTH:0] PRIM_POLY = 9'h11D;

    // Shift-and-add multiply in GF(2^SYMB_WIDTH), reducing by PRIM_POLY on overflow.
    function automatic logic [SYMB_WIDTH-1:0] gf_mult(input logic [SYMB_WIDTH-1:0] a,
                                                       input logic [SYMB_WIDTH-1:0] b);
        logic [SYMB_WIDTH-1:0] acc;
        logic [SYMB_WIDTH-1:0] x;
        acc = '0;
        x   = a;
        for (int i = 0; i < SYMB_WIDTH; i++) begin
            if (b[i]) acc = acc ^ x;
            x = x[SYMB_WIDTH-1] ? ((x << 1) ^ PRIM_POLY[SYMB_WIDTH-1:0]) : (x << 1);
        end
        return acc;
    endfunction
endpackage

module rs_encoder
    import gf_pkg::*;
(
    input  logic                                              aclk,
    input  logic                                              aresetn,
    input  logic                                              s_tvalid,
    output logic                                              s_tready,
    input  logic [BUS_WIDTH_IN_SYMB-1:0][SYMB_WIDTH-1:0]      s_tdata,
    input  logic [BUS_WIDTH_IN_SYMB-1:0]                      s_tkeep,
    input  logic                                              s_tlast,
    input  logic [SYMB_WIDTH-1:0]                             gen_poly [ROOTS_NUM],
    output logic                                              m_tvalid,
    input  logic                                              m_tready,
    output logic [BUS_WIDTH_IN_SYMB-1:0][SYMB_WIDTH-1:0]      m_tdata,
    output logic [BUS_WIDTH_IN_SYMB-1:0]                      m_tkeep,
    output logic                                              m_tlast
);
    localparam int SW        = SYMB_WIDTH;
    localparam int B         = BUS_WIDTH_IN_SYMB;
    localparam int R         = ROOTS_NUM;
    localparam int PAR_BEATS = (R + B - 1) / B;
    localparam int KW        = (PAR_BEATS > 1) ? $clog2(PAR_BEATS) : 1;

    typedef enum logic {
        DATA,
        PARITY
    } state_t;

    state_t                  state_q, state_d;
    logic [R-1:0][SW-1:0]    par_q, par_d, parStep;
    logic [KW-1:0]           beat_q, beat_d;

    // Remainder after folding every kept lane of the current input beat, lane 0 first.
    always_comb begin
        logic [SW-1:0] fb;
        fb      = '0;
        parStep = par_q;
        for (int j = 0; j < B; j++) begin
            if (s_tkeep[j]) begin
                fb = s_tdata[j] ^ parStep[R-1];
                for (int i = R - 1; i >= 1; i--) begin
                    parStep[i] = parStep[i-1] ^ gf_mult(fb, gen_poly[i]);
                end
                parStep[0] = gf_mult(fb, gen_poly[0]);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        par_d    = par_q;
        beat_d   = beat_q;
        s_tready = 1'b0;
        m_tvalid = 1'b0;
        m_tdata  = '0;
        m_tkeep  = '0;
        m_tlast  = 1'b0;
        case (state_q)
            DATA: begin
                s_tready = m_tready;
                m_tvalid = s_tvalid;
                m_tdata  = s_tdata;
                m_tkeep  = s_tkeep;
                if (s_tvalid && m_tready) begin
                    par_d = parStep;
                    if (s_tlast) begin
                        state_d = PARITY;
                        beat_d  = '0;
                    end
                end
            end
            PARITY: begin
                m_tvalid = 1'b1;
                m_tlast  = (beat_q == KW'(PAR_BEATS - 1));
                // Lanes past the last parity symbol stay zero with keep cleared.
                for (int j = 0; j < B; j++) begin
                    if (int'(beat_q) * B + j < R) begin
                        m_tdata[j] = par_q[R - 1 - (int'(beat_q) * B + j)];
                        m_tkeep[j] = 1'b1;
                    end
                end
                if (m_tready) begin
                    if (beat_q == KW'(PAR_BEATS - 1)) begin
                        state_d = DATA;
                        par_d   = '0;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + KW'(1);
                    end
                end
            end
            default: state_d = DATA;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= DATA;
            par_q   <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            par_q   <= par_d;
            beat_q  <= beat_d;
        end
    end
endmodule

// File: tb/tb_rs_encoder.sv
// Scoreboard bench for rs_encoder: expected codeword beats come from a long-division
// model over log/antilog tables; every completed codeword must have zero syndromes.

module tb_rs_encoder;
    import gf_pkg::*;

    localparam int SW      = SYMB_WIDTH;
    localparam int B       = BUS_WIDTH_IN_SYMB;
    localparam int R       = ROOTS_NUM;
    localparam int PB      = (R + B - 1) / B;
    localparam int TIMEOUT = 2000;

    typedef struct packed {
        logic [B-1:0][SW-1:0] data;
        logic [B-1:0]         keep;
        logic                 last;
    } beat_t;

    logic                 aclk = 1'b0;
    logic                 aresetn;
    logic                 s_tvalid;
    logic                 s_tready;
    logic [B-1:0][SW-1:0] s_tdata;
    logic [B-1:0]         s_tkeep;
    logic                 s_tlast;
    logic [SW-1:0]        genPoly [R];
    logic                 m_tvalid;
    logic                 m_tready;
    logic [B-1:0][SW-1:0] m_tdata;
    logic [B-1:0]         m_tkeep;
    logic                 m_tlast;

    logic [7:0] expTab [256];
    int         logTab [256];
    logic [7:0] gFull [R+1];
    beat_t      expQ [$];
    logic [7:0] msg [$];
    logic [7:0] cw [$];
    logic [7:0] streamData [20][10];
    int         streamLen [20];
    int         errors = 0;
    int         checks = 0;
    bit         bpEnable = 1'b0;

    rs_encoder dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .s_tdata  (s_tdata),
        .s_tkeep  (s_tkeep),
        .s_tlast  (s_tlast),
        .gen_poly (genPoly),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tdata  (m_tdata),
        .m_tkeep  (m_tkeep),
        .m_tlast  (m_tlast)
    );

    always #5 aclk = ~aclk;

    function automatic logic [7:0] refMul(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'h00 || b == 8'h00) return 8'h00;
        return expTab[(logTab[a] + logTab[b]) % 255];
    endfunction

    // Antilog tables for x^8+x^4+x^3+x^2+1, then g(x) = prod (x + alpha^i), i = 0..R-1.
    task automatic buildTables();
        logic [8:0] a;
        logic [7:0] root;
        a = 9'h001;
        for (int i = 0; i < 255; i++) begin
            expTab[i] = a[7:0];
            logTab[a[7:0]] = i;
            a = a << 1;
            if (a[8]) a = a ^ 9'h11D;
        end
        expTab[255] = expTab[0];
        logTab[0] = 0;
        for (int d = 0; d <= R; d++) gFull[d] = 8'h00;
        gFull[0] = 8'h01;
        for (int i = 0; i < R; i++) begin
            root = expTab[i];
            for (int d = R; d >= 1; d--) gFull[d] = gFull[d-1] ^ refMul(root, gFull[d]);
            gFull[0] = refMul(root, gFull[0]);
        end
        for (int d = 0; d < R; d++) genPoly[d] = gFull[d];
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic sendBeat(input logic [B-1:0][SW-1:0] d, input logic [B-1:0] kp, input logic lst);
        int waitCnt;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tkeep  = kp;
        s_tlast  = lst;
        waitCnt  = 0;
        forever begin
            @(negedge aclk);
            if (s_tready) break;
            waitCnt++;
            if (waitCnt > TIMEOUT) begin
                checks++;
                errors++;
                $display("[TB] FAIL input_handshake: s_tready stuck at %0b, want 1", s_tready);
                break;
            end
        end
        @(posedge aclk);
        #1;
    endtask

    // Queues expected data and parity beats for the frame in msg, then drives it.
    task automatic applyStimulus(input logic [7:0] pad, input bit emptyTail);
        beat_t      beats [$];
        beat_t      b;
        logic [7:0] divBuf [$];
        logic [7:0] coef;
        int         n;
        int         total;
        int         idx;
        n     = msg.size();
        total = (n + B - 1) / B + (emptyTail ? 1 : 0);
        for (int bt = 0; bt < total; bt++) begin
            b = '0;
            for (int j = 0; j < B; j++) begin
                idx = bt * B + j;
                if (idx < n) begin
                    b.data[j] = msg[idx];
                    b.keep[j] = 1'b1;
                end else begin
                    b.data[j] = pad;
                end
            end
            beats.push_back(b);
            expQ.push_back(b);
        end
        divBuf = msg;
        for (int r = 0; r < R; r++) divBuf.push_back(8'h00);
        for (int t = 0; t < n; t++) begin
            coef = divBuf[t];
            for (int d = 0; d <= R; d++) divBuf[t + R - d] = divBuf[t + R - d] ^ refMul(coef, gFull[d]);
        end
        for (int k = 0; k < PB; k++) begin
            b = '0;
            for (int j = 0; j < B; j++) begin
                idx = k * B + j;
                if (idx < R) begin
                    b.data[j] = divBuf[n + idx];
                    b.keep[j] = 1'b1;
                end
            end
            b.last = (k == PB - 1);
            expQ.push_back(b);
        end
        for (int bt = 0; bt < total; bt++) sendBeat(beats[bt].data, beats[bt].keep, bt == total - 1);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic runStream();
        for (int f = 0; f < 20; f++) begin
            msg.delete();
            for (int i = 0; i < streamLen[f]; i++) msg.push_back(streamData[f][i]);
            applyStimulus(8'h00, 1'b0);
        end
    endtask

    task automatic waitDrain(input string name);
        int n;
        n = 0;
        while (expQ.size() != 0 && n < TIMEOUT) begin
            @(negedge aclk);
            n++;
        end
        if (expQ.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_%s: %0d beats outstanding, want 0", name, expQ.size());
            expQ.delete();
        end
        @(posedge aclk);
        #1;
    endtask

    always @(posedge aclk) begin
        if (bpEnable) begin
            #1;
            m_tready = 1'($urandom_range(0, 1));
        end
    end

    always @(negedge aclk) begin : monitor
        beat_t      e;
        logic [7:0] s;
        bit         bad;
        if (!aresetn) begin
            cw.delete();
        end else if (m_tvalid && m_tready) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL extra_beat: got data=%h keep=%b last=%b, want no beat",
                         m_tdata, m_tkeep, m_tlast);
            end else begin
                e = expQ.pop_front();
                if (m_tdata !== e.data || m_tkeep !== e.keep || m_tlast !== e.last) begin
                    errors++;
                    $display("[TB] FAIL beat: got data=%h keep=%b last=%b, want data=%h keep=%b last=%b",
                             m_tdata, m_tkeep, m_tlast, e.data, e.keep, e.last);
                end
            end
            for (int j = 0; j < B; j++) if (m_tkeep[j]) cw.push_back(m_tdata[j]);
            if (m_tlast) begin
                bad = 1'b0;
                for (int i = 0; i < R; i++) begin
                    s = 8'h00;
                    foreach (cw[t]) s = refMul(s, expTab[i]) ^ cw[t];
                    if (s != 8'h00) bad = 1'b1;
                end
                checks++;
                if (bad) begin
                    errors++;
                    $display("[TB] FAIL syndromes: got nonzero syndrome over %0d symbols, want all 0", cw.size());
                end
                cw.delete();
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation still running, want finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        aresetn  = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tlast  = 1'b0;
        m_tready = 1'b0;
        buildTables();
        #2;
        s_tvalid = 1'b1;
        #1;
        checkOutput("rst_m_tvalid_hi", 32'(m_tvalid), 32'd1);
        checkOutput("rst_s_tready_lo", 32'(s_tready), 32'd0);
        checkOutput("rst_m_tlast", 32'(m_tlast), 32'd0);
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        #1;
        checkOutput("rst_m_tvalid_lo", 32'(m_tvalid), 32'd0);
        checkOutput("rst_s_tready_hi", 32'(s_tready), 32'd1);
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        msg.delete();
        repeat (12) msg.push_back(8'h00);
        applyStimulus(8'h00, 1'b0);
        msg.delete();
        msg.push_back(8'h01);
        applyStimulus(8'hAA, 1'b0);
        msg.delete();
        for (int i = 0; i < 11; i++) msg.push_back(8'(8'h10 + i));
        applyStimulus(8'hEE, 1'b0);
        msg.delete();
        msg.push_back(8'hC3);
        msg.push_back(8'h5A);
        msg.push_back(8'h0F);
        msg.push_back(8'hF0);
        applyStimulus(8'h55, 1'b1);
        waitDrain("directed");

        for (int f = 0; f < 20; f++) begin
            streamLen[f] = $urandom_range(1, 10);
            for (int i = 0; i < 10; i++) streamData[f][i] = 8'($urandom_range(0, 255));
        end
        runStream();
        waitDrain("stream");
        bpEnable = 1'b1;
        runStream();
        waitDrain("stream_bp");
        bpEnable = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        m_tready = 1'b1;

        // Message {01}: parity is g itself, so lane 0 of beat 0 is g5 = 0x3F and
        // lane 1 of beat 1 is g0 = alpha^15 = 0x26.
        msg.delete();
        msg.push_back(8'h01);
        applyStimulus(8'h33, 1'b0);
        m_tready = 1'b0;
        #1;
        checkOutput("par0_m_tvalid", 32'(m_tvalid), 32'd1);
        checkOutput("par0_s_tready", 32'(s_tready), 32'd0);
        checkOutput("par0_lane0", 32'(m_tdata[0]), 32'h3F);
        checkOutput("par0_keep", 32'(m_tkeep), 32'hF);
        checkOutput("par0_last", 32'(m_tlast), 32'd0);
        repeat (2) @(posedge aclk);
        #1;
        checkOutput("par0_hold_lane0", 32'(m_tdata[0]), 32'h3F);
        m_tready = 1'b1;
        @(posedge aclk);
        #1;
        m_tready = 1'b0;
        #1;
        checkOutput("par1_lane1", 32'(m_tdata[1]), 32'h26);
        checkOutput("par1_lane3", 32'(m_tdata[3]), 32'h00);
        checkOutput("par1_keep", 32'(m_tkeep), 32'h3);
        checkOutput("par1_last", 32'(m_tlast), 32'd1);
        expQ.delete();
        aresetn = 1'b0;
        #1;
        checkOutput("midrst_m_tvalid", 32'(m_tvalid), 32'd0);
        checkOutput("midrst_m_tlast", 32'(m_tlast), 32'd0);
        m_tready = 1'b1;
        #1;
        checkOutput("midrst_s_tready", 32'(s_tready), 32'd1);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        msg.delete();
        msg.push_back(8'h01);
        applyStimulus(8'h00, 1'b0);
        waitDrain("post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
